// File: rtl/display_scanout_if.sv
// Frame-buffer read port between the scan-out engine (master) and the pixel memory (slave).
interface display_scanout_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8
);
    logic              FrameRd;
    logic [ADDR_W-1:0] FrameRAddr;
    logic [PIX_W-1:0]  FrameDataIn;

    modport master (output FrameRd, output FrameRAddr, input FrameDataIn);
    modport slave  (input FrameRd, input FrameRAddr, output FrameDataIn);
endinterface

// File: rtl/display_scanout.sv
// Raster scan-out engine: walks active/blank timing, reads the frame buffer and emits pixels.
// FrameDataIn is captured on the edge that closes the FrameRd cycle, so pixels trail reads by one cycle.
module display_scanout #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CSDisplay,
    input  logic [9:0]           HBOut_PD,
    input  logic [9:0]           VBOut_PD,
    input  logic [9:0]           AIPOut_PD,
    input  logic [9:0]           AILOut_PD,
    display_scanout_if.master    fb,
    output logic [PIX_W-1:0]     PixelOut,
    output logic                 PixelValid,
    output logic                 HBlank,
    output logic                 VBlank,
    output logic                 LineStart,
    output logic                 FrameDone
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [9:0]        aip_r, ail_r, hb_r, vb_r;
    logic [9:0]        pix_cnt_r, line_cnt_r;
    logic [19:0]       vb_cyc_r;
    logic [19:0]       line_len_s;
    logic [ADDR_W-1:0] addr_r;
    logic [PIX_W-1:0]  pixel_r;
    logic              pixel_valid_r;
    logic              start_s, line_end_s, last_line_s, frame_end_s, vb_line_end_s;

    // Next-state decode; line and frame completion are resolved after the per-state decode.
    always_comb begin
        state_s       = state_r;
        start_s       = 1'b0;
        line_end_s    = 1'b0;
        frame_end_s   = 1'b0;
        vb_line_end_s = 1'b0;
        line_len_s    = {10'd0, aip_r} + {10'd0, hb_r};
        last_line_s   = (line_cnt_r == ail_r - 10'd1);
        case (state_r)
            IDLE: begin
                if (CSDisplay && (AIPOut_PD != 10'd0) && (AILOut_PD != 10'd0)) begin
                    start_s = 1'b1;
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (pix_cnt_r == aip_r - 10'd1) begin
                    if (hb_r != 10'd0) begin
                        state_s = HBLANK;
                    end else begin
                        line_end_s = 1'b1;
                    end
                end else begin
                    state_s = ACTIVE;
                end
            end
            HBLANK: begin
                if (pix_cnt_r == hb_r - 10'd1) begin
                    line_end_s = 1'b1;
                end else begin
                    state_s = HBLANK;
                end
            end
            VBLANK: begin
                // Vertical blank is counted as VB blank lines of (AIP+HB) cycles each.
                if (vb_cyc_r == line_len_s - 20'd1) begin
                    vb_line_end_s = 1'b1;
                    if (line_cnt_r == vb_r - 10'd1) begin
                        frame_end_s = 1'b1;
                    end else begin
                        state_s = VBLANK;
                    end
                end else begin
                    state_s = VBLANK;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (line_end_s) begin
            if (!last_line_s) begin
                state_s = ACTIVE;
            end else if (vb_r != 10'd0) begin
                state_s = VBLANK;
            end else begin
                frame_end_s = 1'b1;
            end
        end else begin
            state_s = state_s;
        end
        if (frame_end_s) begin
            state_s = CSDisplay ? ACTIVE : IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // State, timing latches, counters, read address and pixel register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            aip_r         <= 10'd0;
            ail_r         <= 10'd0;
            hb_r          <= 10'd0;
            vb_r          <= 10'd0;
            pix_cnt_r     <= 10'd0;
            line_cnt_r    <= 10'd0;
            vb_cyc_r      <= 20'd0;
            addr_r        <= '0;
            pixel_r       <= '0;
            pixel_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                aip_r <= AIPOut_PD;
                ail_r <= AILOut_PD;
                hb_r  <= HBOut_PD;
                vb_r  <= VBOut_PD;
            end
            if ((state_s != state_r) || line_end_s || frame_end_s ||
                (state_r == IDLE) || (state_r == VBLANK)) begin
                pix_cnt_r <= 10'd0;
            end else begin
                pix_cnt_r <= pix_cnt_r + 10'd1;
            end
            // line_cnt counts active lines, then is reused to count vertical blank lines.
            if (start_s || frame_end_s || (line_end_s && last_line_s)) begin
                line_cnt_r <= 10'd0;
            end else if (line_end_s || vb_line_end_s) begin
                line_cnt_r <= line_cnt_r + 10'd1;
            end
            if ((state_r == VBLANK) && !vb_line_end_s) begin
                vb_cyc_r <= vb_cyc_r + 20'd1;
            end else begin
                vb_cyc_r <= 20'd0;
            end
            if (start_s || frame_end_s) begin
                addr_r <= '0;
            end else if (state_r == ACTIVE) begin
                addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            pixel_valid_r <= (state_r == ACTIVE);
            if (state_r == ACTIVE) begin
                pixel_r <= fb.FrameDataIn;
            end
        end
    end

    assign fb.FrameRd    = (state_r == ACTIVE);
    assign fb.FrameRAddr = addr_r;
    assign LineStart     = (state_r == ACTIVE) && (pix_cnt_r == 10'd0);
    assign HBlank        = (state_r == HBLANK);
    assign VBlank        = (state_r == VBLANK);
    assign FrameDone     = frame_end_s;
    assign PixelOut      = pixel_r;
    assign PixelValid    = pixel_valid_r;
endmodule

// File: tb/tb_display_scanout.sv
// Randomized bench for display_scanout against a frame-level timing model built from nested loops.
module tb_display_scanout;
    localparam int AW = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       CSDisplay;
    logic [9:0] HBOut_PD, VBOut_PD, AIPOut_PD, AILOut_PD;
    logic [7:0] PixelOut;
    logic       PixelValid, HBlank, VBlank, LineStart, FrameDone;
    logic [7:0] data_ofs;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic          ls;
        logic          hbf;
        logic          vbf;
        logic          done;
    } cyc_t;

    cyc_t          exp_q[$];
    logic          prev_rd;
    logic [AW-1:0] prev_addr;
    logic [7:0]    last_pix;

    display_scanout_if #(.ADDR_W(AW), .PIX_W(8)) fb ();

    display_scanout #(.ADDR_W(AW), .PIX_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .CSDisplay  (CSDisplay),
        .HBOut_PD   (HBOut_PD),
        .VBOut_PD   (VBOut_PD),
        .AIPOut_PD  (AIPOut_PD),
        .AILOut_PD  (AILOut_PD),
        .fb         (fb),
        .PixelOut   (PixelOut),
        .PixelValid (PixelValid),
        .HBlank     (HBlank),
        .VBlank     (VBlank),
        .LineStart  (LineStart),
        .FrameDone  (FrameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] data_of(logic [AW-1:0] a);
        return {3'd0, a} + data_ofs;
    endfunction

    assign fb.FrameDataIn = data_of(fb.FrameRAddr);

    function automatic logic [31:0] pack(logic rd, logic [AW-1:0] a, logic ls, logic hbf,
                                         logic vbf, logic dn, logic pv, logic [7:0] px);
        return {13'd0, rd, (rd ? a : {AW{1'b0}}), ls, hbf, vbf, dn, pv, px};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One full frame: AIL lines of AIP reads then HB blanks, then VB*(AIP+HB) vertical blank cycles.
    task automatic build_frame(input int aip, input int ail, input int hb, input int vb);
        int a = 0;
        cyc_t c;
        exp_q.delete();
        for (int l = 0; l < ail; l++) begin
            for (int p = 0; p < aip; p++) begin
                c = '0; c.rd = 1'b1; c.addr = AW'(a % (1 << AW)); c.ls = (p == 0);
                exp_q.push_back(c);
                a++;
            end
            for (int h = 0; h < hb; h++) begin
                c = '0; c.hbf = 1'b1;
                exp_q.push_back(c);
            end
        end
        for (int v = 0; v < vb * (aip + hb); v++) begin
            c = '0; c.vbf = 1'b1;
            exp_q.push_back(c);
        end
        c = exp_q[exp_q.size() - 1];
        c.done = 1'b1;
        exp_q[exp_q.size() - 1] = c;
    endtask

    task automatic step_check(input string tag, input cyc_t e);
        logic [7:0] ep;
        @(negedge clk);
        ep = prev_rd ? data_of(prev_addr) : last_pix;
        check(tag, pack(fb.FrameRd, fb.FrameRAddr, LineStart, HBlank, VBlank, FrameDone, PixelValid, PixelOut),
                   pack(e.rd, e.addr, e.ls, e.hbf, e.vbf, e.done, prev_rd, ep));
        last_pix  = ep;
        prev_rd   = e.rd;
        prev_addr = e.addr;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) step_check(tag, cyc_t'(0));
    endtask

    // Starts from IDLE at a negedge; CSDisplay is dropped after cycle drop_cyc of the last frame.
    task automatic run_frames(input string tag, input int aip, input int ail, input int hb, input int vb,
                              input int nfr, input int drop_cyc, input bit scramble);
        AIPOut_PD = 10'(aip); AILOut_PD = 10'(ail); HBOut_PD = 10'(hb); VBOut_PD = 10'(vb);
        CSDisplay = 1'b1;
        for (int f = 0; f < nfr; f++) begin
            build_frame(aip, ail, hb, vb);
            for (int i = 0; i < exp_q.size(); i++) begin
                step_check(tag, exp_q[i]);
                if (f == nfr - 1 && i + 1 == drop_cyc) begin
                    CSDisplay = 1'b0;
                    if (scramble) begin
                        AIPOut_PD = 10'($urandom_range(1, 9));
                        AILOut_PD = 10'($urandom_range(1, 9));
                        HBOut_PD  = 10'($urandom_range(0, 9));
                        VBOut_PD  = 10'($urandom_range(0, 9));
                    end
                end
            end
        end
        idle_cycles({tag, "_idle"}, 3);
    endtask

    initial begin
        reset = 1'b1; CSDisplay = 1'b0; data_ofs = 8'h10;
        AIPOut_PD = 10'd0; AILOut_PD = 10'd0; HBOut_PD = 10'd0; VBOut_PD = 10'd0;
        prev_rd = 1'b0; prev_addr = '0; last_pix = 8'h00;
        repeat (2) @(posedge clk);
        CSDisplay = 1'b1; AIPOut_PD = 10'd4; AILOut_PD = 10'd2;
        idle_cycles("reset_state", 2);
        reset = 1'b0; CSDisplay = 1'b0;
        idle_cycles("post_reset_idle", 2);

        // 4x2 pixels, HB=2, VB=1: two back-to-back 18-cycle frames with data addr+0x10.
        run_frames("basic", 4, 2, 2, 1, 2, 18, 1'b0);
        // No blanking: continuous reads, LineStart at cycles 1 and 4.
        run_frames("noblank", 3, 2, 0, 0, 1, 6, 1'b0);
        // Zero active lines must never leave IDLE.
        AIPOut_PD = 10'd4; AILOut_PD = 10'd0; HBOut_PD = 10'd2; VBOut_PD = 10'd1; CSDisplay = 1'b1;
        idle_cycles("ail_zero", 10);
        AIPOut_PD = 10'd0; AILOut_PD = 10'd3;
        idle_cycles("aip_zero", 5);
        CSDisplay = 1'b0;
        idle_cycles("cs_off", 2);
        // Enable dropped at cycle 5 with timing inputs scrambled: frame still completes.
        run_frames("drop_mid", 4, 2, 2, 1, 1, 5, 1'b1);
        // Address wraps modulo 2^AW (36 reads through a 5-bit address).
        data_ofs = 8'h40;
        run_frames("wrap", 6, 6, 1, 0, 1, 1, 1'b0);

        // Reset in the middle of ACTIVE, then restart from address 0.
        data_ofs = 8'h10;
        AIPOut_PD = 10'd4; AILOut_PD = 10'd2; HBOut_PD = 10'd2; VBOut_PD = 10'd1; CSDisplay = 1'b1;
        build_frame(4, 2, 2, 1);
        for (int i = 0; i < 3; i++) step_check("pre_reset", exp_q[i]);
        reset = 1'b1;
        prev_rd = 1'b0; last_pix = 8'h00;
        step_check("mid_reset", cyc_t'(0));
        reset = 1'b0;
        run_frames("after_reset", 4, 2, 2, 1, 1, 18, 1'b0);

        for (int r = 0; r < 10; r++) begin
            int aip = $urandom_range(1, 6);
            int ail = $urandom_range(1, 4);
            int hb  = $urandom_range(0, 3);
            int vb  = $urandom_range(0, 2);
            int nfr = $urandom_range(1, 3);
            data_ofs = 8'($urandom);
            run_frames("rand", aip, ail, hb, vb, nfr,
                       $urandom_range(1, (aip + hb) * (ail + vb)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
